// File: rtl/latch_word_serializer_pkg.sv
// Shared definitions for the latch_word_serializer block: FSM state encoding
// and the default word width.
package latch_word_serializer_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage : latch_word_serializer_pkg

// File: rtl/latch_word_serializer_if.sv
// Parallel-in / serial-out handshake bundle between a word source, the
// serializer and the downstream bit consumer.
interface latch_word_serializer_if
  import latch_word_serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             Load;
  logic [WIDTH-1:0] D;
  logic             Ready;
  logic             Q;
  logic             Valid;
  logic             Busy;
  logic             Done;

  // The master is the environment: it supplies words and accepts bits.
  modport master (
    output Load, D, Ready,
    input  Q, Valid, Busy, Done
  );

  modport slave (
    input  Load, D, Ready,
    output Q, Valid, Busy, Done
  );

endinterface : latch_word_serializer_if

// File: rtl/latch_word_serializer_shift_reg_piso.sv
// Parameterized parallel-load shift register; shifts toward the output end
// with zero fill, so the serial output is always the next bit to send.
module shift_reg_piso
  import latch_word_serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             shift_en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             serial_o
);

  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] sreg_d;

  always_comb begin
    sreg_d = sreg_q;
    if (load_i) begin
      sreg_d = d_i;
    end else if (shift_en_i) begin
      sreg_d = LSB_FIRST ? (sreg_q >> 1) : (sreg_q << 1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q <= '0;
    end else begin
      sreg_q <= sreg_d;
    end
  end

  assign serial_o = LSB_FIRST ? sreg_q[0] : sreg_q[WIDTH-1];

endmodule : shift_reg_piso

// File: rtl/latch_word_serializer.sv
// Captures a parallel word and shifts it out one bit per valid/ready
// transfer, followed by a one-cycle Done pulse.
module latch_word_serializer
  import latch_word_serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit LSB_FIRST = 1'b0
) (
  input logic                    Clk,
  input logic                    Rst,
  latch_word_serializer_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               valid_q;
  logic               busy_q;
  logic               done_q;
  logic               capture;
  logic               transfer;
  logic               last_bit;
  logic               serial_bit;

  assign capture  = (state_q == S_IDLE) && bus.Load;
  assign transfer = valid_q && bus.Ready;
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
  assign cnt_d    = cnt_q + CNT_W'(1);

  shift_reg_piso #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_piso (
    .clk        (Clk),
    .rst        (Rst),
    .load_i     (capture),
    .shift_en_i (transfer),
    .d_i        (bus.D),
    .serial_o   (serial_bit)
  );

  // Outputs are registered alongside the state so that reset clears them
  // asynchronously and they never glitch with the inputs.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.Load) begin
            state_q <= S_SHIFT;
            cnt_q   <= '0;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end
          done_q <= 1'b0;
        end
        S_SHIFT: begin
          if (bus.Ready) begin
            cnt_q <= cnt_d;
            if (last_bit) begin
              state_q <= S_DONE;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Q     = valid_q & serial_bit;
  assign bus.Valid = valid_q;
  assign bus.Busy  = busy_q;
  assign bus.Done  = done_q;

endmodule : latch_word_serializer

// File: tb/tb_latch_word_serializer.sv
// Self-checking bench: MSB-first and LSB-first instances driven in lockstep
// and compared against a queue-based reference model plus fixed vectors.
module tb_latch_word_serializer;
  import latch_word_serializer_pkg::*;

  localparam int W = 8;

  logic Clk = 1'b0;
  logic Rst;

  int vectors     = 0;
  int miscompares = 0;

  bit qM[$];
  bit qL[$];
  bit donePending;

  always #5 Clk = ~Clk;

  latch_word_serializer_if #(.WIDTH(W)) busM ();
  latch_word_serializer_if #(.WIDTH(W)) busL ();

  latch_word_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dutM (
    .Clk (Clk),
    .Rst (Rst),
    .bus (busM)
  );

  latch_word_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dutL (
    .Clk (Clk),
    .Rst (Rst),
    .bus (busL)
  );

  typedef struct {
    bit         load;
    logic [7:0] d;
    bit         ready;
    bit         qMsb;
    bit         qLsb;
    bit         valid;
    bit         busy;
    bit         done;
  } vec_t;

  vec_t tbl[10];

  task automatic checkOutput(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    qM.delete();
    qL.delete();
    donePending = 1'b0;
  endtask

  // Word-level reference: a queue of pending bits per output order, and a
  // flag for the single completion cycle that follows the last accepted bit.
  task automatic modelEdge(input bit load, input logic [W-1:0] d, input bit ready);
    if (donePending) begin
      donePending = 1'b0;
    end else if (qM.size() != 0) begin
      if (ready) begin
        void'(qM.pop_front());
        void'(qL.pop_front());
        if (qM.size() == 0) donePending = 1'b1;
      end
    end else if (load) begin
      for (int i = 0; i < W; i++) begin
        qM.push_back(d[W-1-i]);
        qL.push_back(d[i]);
      end
    end
  endtask

  task automatic checkModel();
    logic evM;
    logic evL;
    evM = (qM.size() != 0);
    evL = (qL.size() != 0);
    checkOutput("M.Valid", busM.Valid, evM);
    checkOutput("M.Q",     busM.Q,     evM ? qM[0] : 1'b0);
    checkOutput("M.Busy",  busM.Busy,  evM || donePending);
    checkOutput("M.Done",  busM.Done,  donePending);
    checkOutput("L.Valid", busL.Valid, evL);
    checkOutput("L.Q",     busL.Q,     evL ? qL[0] : 1'b0);
    checkOutput("L.Busy",  busL.Busy,  evL || donePending);
    checkOutput("L.Done",  busL.Done,  donePending);
  endtask

  task automatic applyStimulus(input bit load, input logic [W-1:0] d, input bit ready);
    @(negedge Clk);
    busM.Load = load; busM.D = d; busM.Ready = ready;
    busL.Load = load; busL.D = d; busL.Ready = ready;
    @(posedge Clk);
    modelEdge(load, d, ready);
    #1;
    checkModel();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b1);
  endtask

  initial begin
    int doneCount;
    int rises[$];
    bit prevValid;
    bit rdyPat[4];
    rdyPat = '{1'b1, 1'b0, 1'b0, 1'b1};

    // Fixed MSB/LSB vectors for 8'hA5 with Ready held high.
    tbl[0] = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    busM.Load = 1'b0; busM.D = '0; busM.Ready = 1'b0;
    busL.Load = 1'b0; busL.D = '0; busL.Ready = 1'b0;
    Rst = 1'b1;
    modelReset();
    #1;
    checkModel();
    repeat (2) @(negedge Clk);
    Rst = 1'b0;

    idleCycles(2);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(tbl[i].load, tbl[i].d, tbl[i].ready);
      checkOutput("tbl.MQ",    busM.Q,     tbl[i].qMsb);
      checkOutput("tbl.LQ",    busL.Q,     tbl[i].qLsb);
      checkOutput("tbl.Valid", busM.Valid, tbl[i].valid);
      checkOutput("tbl.Busy",  busM.Busy,  tbl[i].busy);
      checkOutput("tbl.Done",  busM.Done,  tbl[i].done);
    end

    // 8'h01: LSB-first sends its 1 first, MSB-first sends it last.
    applyStimulus(1'b1, 8'h01, 1'b1);
    checkOutput("h01.L.first", busL.Q, 1'b1);
    checkOutput("h01.M.first", busM.Q, 1'b0);
    idleCycles(10);

    // Backpressure with Ready pattern 1,0,0,1.
    doneCount = 0;
    applyStimulus(1'b1, 8'hF0, 1'b0);
    for (int i = 0; i < 24; i++) begin
      applyStimulus(1'b0, 8'h00, rdyPat[i % 4]);
      if (busM.Done) doneCount++;
    end
    checkInt("bp.doneCount", doneCount, 1);
    idleCycles(2);

    // Load during SHIFT must not disturb the word in flight.
    applyStimulus(1'b1, 8'h0F, 1'b1);
    applyStimulus(1'b0, 8'h0F, 1'b1);
    applyStimulus(1'b1, 8'hFF, 1'b1);
    applyStimulus(1'b1, 8'hFF, 1'b0);
    idleCycles(8);

    // Reset after three transfers of 8'hA5.
    applyStimulus(1'b1, 8'hA5, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b1);
    @(negedge Clk);
    Rst = 1'b1;
    modelReset();
    #1;
    checkOutput("rst.Q",     busM.Q,     1'b0);
    checkOutput("rst.Valid", busM.Valid, 1'b0);
    checkOutput("rst.Busy",  busM.Busy,  1'b0);
    checkOutput("rst.Done",  busM.Done,  1'b0);
    checkModel();
    @(negedge Clk);
    Rst = 1'b0;
    applyStimulus(1'b1, 8'h3C, 1'b1);
    checkOutput("rst.3C.M.first", busM.Q, 1'b0);
    idleCycles(10);

    // Back-to-back: Load held high gives a WIDTH+2 cycle period.
    prevValid = 1'b0;
    for (int i = 0; i < 24; i++) begin
      applyStimulus(1'b1, W'($urandom), 1'b1);
      if (busM.Valid && !prevValid) rises.push_back(i);
      prevValid = busM.Valid;
    end
    if (rises.size() >= 2) begin
      checkInt("b2b.period", rises[1] - rises[0], W + 2);
    end else begin
      checkInt("b2b.starts", rises.size(), 2);
    end
    applyStimulus(1'b0, '0, 1'b1);
    idleCycles(12);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 3) == 0), W'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_latch_word_serializer
